sudoku_group_checker: RTL and testbench

//  Streaming uniqueness checker for one sudoku group (row, column or box).

---
 rtl/sudoku_group_checker_if.sv | 40 ++++
 rtl/sudoku_group_checker.sv | 127 ++++++++++++
 tb/tb_sudoku_group_checker.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sudoku_group_checker_if.sv
// Handshake and verdict bundle for sudoku_group_checker.
//   master: group source and verdict consumer (drives start, partial, in_valid, digit)
//   slave : the checker (drives in_ready, busy, done and the verdict fields)
// Signals:
//   start, partial            group control
//   in_valid, in_ready, digit digit stream handshake
//   busy, done                status; done is a one-cycle pulse
//   unique_valid, err_code,
//   first_bad_digit,
//   first_bad_index           verdict, stable from done until the next start
interface sudoku_group_checker_if #(
  parameter int N  = 9,
  parameter int DW = 4
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic          start;
  logic          partial;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] digit;
  logic          busy;
  logic          done;
  logic          unique_valid;
  logic [1:0]    err_code;
  logic [DW-1:0] first_bad_digit;
  logic [IW-1:0] first_bad_index;

  modport master (
    output start, partial, in_valid, digit,
    input  in_ready, busy, done, unique_valid, err_code,
           first_bad_digit, first_bad_index
  );

  modport slave (
    input  start, partial, in_valid, digit,
    output in_ready, busy, done, unique_valid, err_code,
           first_bad_digit, first_bad_index
  );
endinterface

// File: rtl/sudoku_group_checker.sv
// Streaming uniqueness checker for one sudoku group (row, column or box).
// Takes N digits, one per accepted handshake, records the first duplicate or
// out-of-range digit and reports a registered verdict with a done pulse the
// cycle after the N-th accept. In partial mode a 0 digit is a blank cell.
// Ports:
//   clock    rising-edge clock
//   reset_L  asynchronous active-low reset
//   bus      sudoku_group_checker_if.slave (handshake, status and verdict)
module sudoku_group_checker #(
  parameter int N  = 9,
  parameter int DW = 4
) (
  input  logic                  clock,
  input  logic                  reset_L,
  sudoku_group_checker_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_DUP   = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;

  typedef enum logic [1:0] {IDLE, COLLECT, REPORT} state_t;

  state_t        state;
  logic [N-1:0]  seen;
  logic [CW-1:0] count;
  logic          partial_q;
  logic          busy_q;
  logic          done_q;
  logic          unique_q;
  logic [1:0]    err_q;
  logic [DW-1:0] bad_digit_q;
  logic [IW-1:0] bad_index_q;

  logic          in_ready;
  logic          accept;
  logic [N-1:0]  digit_onehot;
  logic          is_blank;
  logic          is_range;
  logic          is_dup;
  logic          err_now;
  logic [1:0]    err_kind;

  assign in_ready = (state == COLLECT) && !bus.start;
  assign accept   = bus.in_valid && in_ready;

  // One-hot of the digit over 1..N; all-zero for 0 or anything above N,
  // which keeps the seen-mask lookup in range without indexing by digit.
  always_comb begin
    digit_onehot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      digit_onehot[i] = (bus.digit == DW'(i + 1));
    end
  end

  always_comb begin
    is_blank = (bus.digit == '0) && partial_q;
    is_range = !is_blank && ((bus.digit == '0) || (bus.digit > DW'(N)));
    is_dup   = !is_blank && !is_range && ((seen & digit_onehot) != '0);
    err_now  = is_range || is_dup;
    err_kind = is_range ? ERR_RANGE : ERR_DUP;
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state       <= IDLE;
      seen        <= '0;
      count       <= '0;
      partial_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      unique_q    <= 1'b0;
      err_q       <= ERR_NONE;
      bad_digit_q <= '0;
      bad_index_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.start) begin
        state       <= COLLECT;
        busy_q      <= 1'b1;
        seen        <= '0;
        count       <= '0;
        partial_q   <= bus.partial;
        unique_q    <= 1'b0;
        err_q       <= ERR_NONE;
        bad_digit_q <= '0;
        bad_index_q <= '0;
      end else begin
        case (state)
          IDLE: ;
          COLLECT: begin
            if (accept) begin
              count <= count + CW'(1);
              if (err_now && (err_q == ERR_NONE)) begin
                err_q       <= err_kind;
                bad_digit_q <= bus.digit;
                bad_index_q <= IW'(count);
              end
              if (!err_now && !is_blank) begin
                seen <= seen | digit_onehot;
              end
              if (count == CW'(N - 1)) begin
                state  <= REPORT;
                busy_q <= 1'b0;
                done_q <= 1'b1;
                // Include an error raised by this final digit itself.
                unique_q <= (err_q == ERR_NONE) && !err_now;
              end
            end
          end
          REPORT:  state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.unique_valid    = unique_q;
  assign bus.err_code        = err_q;
  assign bus.first_bad_digit = bad_digit_q;
  assign bus.first_bad_index = bad_index_q;
endmodule

// File: tb/tb_sudoku_group_checker.sv
// Self-checking bench for sudoku_group_checker (N=9, DW=4): directed vector
// table, restart and asynchronous-reset sequences, and randomized groups
// checked against a list-based reference model.
module tb_sudoku_group_checker;
  localparam int N  = 9;
  localparam int DW = 4;

  logic clock;
  logic reset_L;

  sudoku_group_checker_if #(.N(N), .DW(DW)) bus ();

  sudoku_group_checker #(.N(N), .DW(DW)) dut (
    .clock   (clock),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Digits of the current group; index 0 is the first digit sent.
  logic [0:8][3:0] cur;

  typedef struct {
    bit              p;
    logic [0:8][3:0] d;
    bit              uv;
    logic [1:0]      ec;
    int              fbd;
    int              fbi;
    string           name;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: scan the list; first blank-skipped cell that is out of range
  // or equals an earlier cell is the first error.
  task automatic model(input bit p, input logic [0:8][3:0] d,
                       output bit uv, output logic [1:0] ec,
                       output int fbd, output int fbi);
    int v;
    bit hit;
    ec = 2'b00; fbd = 0; fbi = 0;
    for (int i = 0; i < N; i++) begin
      if (ec == 2'b00) begin
        v = int'(d[i]);
        if (!(v == 0 && p)) begin
          if (v == 0 || v > N) begin
            ec = 2'b10; fbd = v; fbi = i;
          end else begin
            hit = 1'b0;
            for (int j = 0; j < i; j++) if (int'(d[j]) == v) hit = 1'b1;
            if (hit) begin
              ec = 2'b01; fbd = v; fbi = i;
            end
          end
        end
      end
    end
    uv = (ec == 2'b00);
  endtask

  task automatic begin_group(input bit p);
    @(negedge clock);
    bus.start = 1'b1; bus.partial = p; bus.in_valid = 1'b0;
    @(negedge clock);
    bus.start = 1'b0; bus.partial = 1'b0;
    #1;
    chk("start_busy", bus.busy, 1);
    chk("start_cleared", {bus.unique_valid, bus.err_code, bus.done}, 0);
    chk("collect_ready", bus.in_ready, 1);
  endtask

  // Feed cur[0..n-1]; called at a negedge. If last, expect done right after.
  task automatic feed(input bit gaps, input int n, input bit last);
    int  k = 0;
    int  budget = 0;
    bit  acc;
    while (k < n) begin
      if (budget > 300) begin
        chk("feed_timeout", k, n);
        break;
      end
      bus.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.digit    = cur[k];
      #1;
      acc = bus.in_valid && bus.in_ready;
      @(negedge clock);
      budget++;
      if (acc) k++;
      if (acc && !(last && k == n)) chk("no_early_done", bus.done, 0);
    end
    bus.in_valid = 1'b0;
    if (last) chk("done_pulse", bus.done, 1);
  endtask

  task automatic check_verdict(input string tag, input bit uv, input logic [1:0] ec,
                               input int fbd, input int fbi);
    chk({tag, ".unique_valid"}, bus.unique_valid, uv);
    chk({tag, ".err_code"}, bus.err_code, ec);
    chk({tag, ".first_bad_digit"}, bus.first_bad_digit, fbd);
    chk({tag, ".first_bad_index"}, bus.first_bad_index, fbi);
    chk({tag, ".report_ready"}, bus.in_ready, 0);
    chk({tag, ".report_busy"}, bus.busy, 0);
    @(negedge clock);
    chk({tag, ".done_one_cycle"}, bus.done, 0);
    chk({tag, ".hold"}, {bus.unique_valid, bus.err_code, bus.first_bad_digit,
                         bus.first_bad_index}, {uv, ec, fbd[3:0], fbi[3:0]});
    chk({tag, ".idle_ready"}, bus.in_ready, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk(tag, {bus.busy, bus.done, bus.unique_valid, bus.err_code,
              bus.first_bad_digit, bus.first_bad_index, bus.in_ready}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit              p, uv;
    logic [1:0]      ec;
    int              fbd, fbi;
    int              perm[9];
    int              tmp, r;

    reset_L = 1'b0;
    bus.start = 1'b0; bus.partial = 1'b0; bus.in_valid = 1'b0; bus.digit = '0;

    vecs.push_back('{1'b0, 36'h123456789, 1'b1, 2'b00, 0,  0, "t1_in_order"});
    vecs.push_back('{1'b0, 36'h537371246, 1'b0, 2'b01, 3,  3, "t2_first_dup"});
    vecs.push_back('{1'b0, 36'hA12345678, 1'b0, 2'b10, 10, 0, "t3_ten_first"});
    vecs.push_back('{1'b0, 36'h012345678, 1'b0, 2'b10, 0,  0, "t3_zero_first"});
    vecs.push_back('{1'b1, 36'h005090010, 1'b1, 2'b00, 0,  0, "t4_partial_ok"});
    vecs.push_back('{1'b1, 36'h005090015, 1'b0, 2'b01, 5,  8, "t4_partial_dup"});
    vecs.push_back('{1'b0, 36'h999999999, 1'b0, 2'b01, 9,  1, "all_nines"});
    vecs.push_back('{1'b0, 36'h12345678F, 1'b0, 2'b10, 15, 8, "range_last"});
    vecs.push_back('{1'b0, 36'h123405678, 1'b0, 2'b10, 0,  4, "zero_not_blank"});
    vecs.push_back('{1'b1, 36'h000000000, 1'b1, 2'b00, 0,  0, "all_blank"});
    vecs.push_back('{1'b1, 36'h0000000A0, 1'b0, 2'b10, 10, 7, "partial_range"});
    vecs.push_back('{1'b0, 36'h987654321, 1'b1, 2'b00, 0,  0, "reversed"});

    // Reset state
    repeat (3) @(negedge clock);
    check_all_zero("reset_outputs");
    reset_L = 1'b1;
    @(negedge clock);
    bus.in_valid = 1'b1;
    #1;
    chk("idle_ready", bus.in_ready, 0);
    @(negedge clock);
    chk("idle_no_accept", {bus.busy, bus.done}, 0);
    bus.in_valid = 1'b0;

    // Directed vector table
    for (int i = 0; i < vecs.size(); i++) begin
      cur = vecs[i].d;
      begin_group(vecs[i].p);
      feed(i[0], N, 1'b1);
      check_verdict(vecs[i].name, vecs[i].uv, vecs[i].ec, vecs[i].fbd, vecs[i].fbi);
    end

    // T5: restart after 4 accepts with start and in_valid together
    cur = 36'h999900000;
    begin_group(1'b0);
    feed(1'b0, 4, 1'b0);
    bus.start = 1'b1; bus.partial = 1'b0; bus.in_valid = 1'b1; bus.digit = 4'd5;
    #1;
    chk("t5_start_blocks_ready", bus.in_ready, 0);
    @(negedge clock);
    bus.start = 1'b0; bus.in_valid = 1'b0;
    #1;
    chk("t5_restart_busy", bus.busy, 1);
    chk("t5_restart_cleared", bus.err_code, 0);
    cur = 36'h123456789;
    feed(1'b1, N, 1'b1);
    check_verdict("t5_restart", 1'b1, 2'b00, 0, 0);

    // T6a: asynchronous reset mid-COLLECT
    cur = 36'h119999999;
    begin_group(1'b0);
    feed(1'b0, 3, 1'b0);
    chk("t6a_err_before_reset", bus.err_code, 1);
    #2 reset_L = 1'b0;
    #1 check_all_zero("t6a_async_reset");
    @(negedge clock);
    reset_L = 1'b1;
    bus.in_valid = 1'b1;
    #1 chk("t6a_idle_ready", bus.in_ready, 0);
    @(negedge clock);
    bus.in_valid = 1'b0;
    chk("t6a_idle_busy", bus.busy, 0);

    // T6b: asynchronous reset during the done cycle
    cur = 36'h12345678A;
    begin_group(1'b0);
    feed(1'b0, N, 1'b1);
    chk("t6b_err_before_reset", bus.err_code, 2);
    #2 reset_L = 1'b0;
    #1 check_all_zero("t6b_async_reset");
    @(negedge clock);
    reset_L = 1'b1;
    @(negedge clock);
    check_all_zero("t6b_after_release");

    // Randomized groups against the reference model
    for (int g = 0; g < 40; g++) begin
      for (int i = 0; i < N; i++) perm[i] = i + 1;
      for (int i = N - 1; i > 0; i--) begin
        r = $urandom_range(0, i);
        tmp = perm[i]; perm[i] = perm[r]; perm[r] = tmp;
      end
      for (int i = 0; i < N; i++) cur[i] = 4'(perm[i]);
      p = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: ;
        1: cur[$urandom_range(0, N - 1)] = 4'($urandom_range(0, 15));
        2: for (int m = 0; m < 3; m++) cur[$urandom_range(0, N - 1)] = 4'($urandom_range(0, 15));
        default: begin
          p = 1'b1;
          for (int m = 0; m < 4; m++) cur[$urandom_range(0, N - 1)] = 4'd0;
        end
      endcase
      model(p, cur, uv, ec, fbd, fbi);
      begin_group(p);
      feed(1'b1, N, 1'b1);
      check_verdict($sformatf("rand%0d", g), uv, ec, fbd, fbi);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
